// File: rtl/l2cache_ctrl_nway.sv
// N-way set-associative write-back L2 cache controller with tree-PLRU replacement.
// Keeps tag/valid/dirty/PLRU metadata locally; the line data array is external.
`timescale 1ns/1ps
module l2cache_ctrl_nway #(
  parameter int WAYS     = 4,
  parameter int SETS     = 16,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5,
  parameter int CNT_W    = 32,
  localparam int WAY_W   = $clog2(WAYS),
  localparam int IDX_W   = $clog2(SETS),
  localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [WAY_W-1:0]  data_way,
  output logic              data_load,
  output logic              data_write,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;
  state_t state_reg, state_next;

  logic [WAYS-1:0]  valid_reg [SETS];
  logic [WAYS-1:0]  dirty_reg [SETS];
  logic [TAG_W-1:0] tag_arr   [SETS][WAYS];
  logic [WAYS-2:0]  plru_reg  [SETS];

  logic [IDX_W-1:0] idx_reg;
  logic [TAG_W-1:0] miss_tag_reg;
  logic             wr_reg;
  logic [WAY_W-1:0] victim_reg;
  logic [CNT_W-1:0] hit_count_reg, miss_count_reg, wb_count_reg;

  logic             req;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WAYS-1:0]  hit_vec, inval_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way, inval_way, victim_sel;
  logic             unused_offset;

  assign req           = mem_read | mem_write;
  assign req_tag       = mem_addr[ADDR_W-1 -: TAG_W];
  assign req_idx       = mem_addr[OFFSET_W +: IDX_W];
  assign unused_offset = ^mem_addr[OFFSET_W-1:0];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi]   = valid_reg[req_idx][gi] && (tag_arr[req_idx][gi] == req_tag);
      assign inval_vec[gi] = ~valid_reg[req_idx][gi];
    end
  endgenerate

  // Node index is kept WAY_W wide; the tree is padded by one bit so every index is in range.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  tp;
    logic [WAY_W-1:0] n;
    tp = {1'b0, t};
    n  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      tp[n] = w[WAY_W-1-l];
      n     = (n << 1) + WAY_W'(1) + WAY_W'(w[WAY_W-1-l]);
    end
    return tp[WAYS-2:0];
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
    logic [WAYS-1:0]  tp;
    logic [WAY_W-1:0] n, w;
    logic             d;
    tp = {1'b0, t};
    n  = '0;
    w  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d            = ~tp[n];
      w[WAY_W-1-l] = d;
      n            = (n << 1) + WAY_W'(1) + WAY_W'(d);
    end
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    hit       = |hit_vec;
    hit_way   = '0;
    inval_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i])   hit_way   = WAY_W'(i);
      if (inval_vec[i]) inval_way = WAY_W'(i);
    end
    victim_sel = (|inval_vec) ? inval_way : plru_victim(plru_reg[req_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_resp   = 1'b0;
    pmem_addr  = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    data_way   = '0;
    data_load  = 1'b0;
    data_write = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp   = 1'b1;
            data_way   = hit_way;
            data_write = mem_write;
          end else if (valid_reg[req_idx][victim_sel] && dirty_reg[req_idx][victim_sel]) begin
            state_next = WB;
          end else begin
            state_next = FILL;
          end
        end
      end
      WB: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_arr[idx_reg][victim_reg], idx_reg, {OFFSET_W{1'b0}}};
        data_way   = victim_reg;
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        pmem_addr = {miss_tag_reg, idx_reg, {OFFSET_W{1'b0}}};
        data_way  = victim_reg;
        if (pmem_resp) begin
          data_load  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        mem_resp   = 1'b1;
        data_way   = victim_reg;
        data_write = wr_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Miss context is latched so a dropped request still completes consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
      idx_reg        <= '0;
      miss_tag_reg   <= '0;
      wr_reg         <= 1'b0;
      victim_reg     <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
      wb_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req && hit) begin
            plru_reg[req_idx] <= plru_touch(plru_reg[req_idx], hit_way);
            if (mem_write) dirty_reg[req_idx][hit_way] <= 1'b1;
            hit_count_reg <= sat_inc(hit_count_reg);
          end else if (req) begin
            miss_count_reg <= sat_inc(miss_count_reg);
            idx_reg        <= req_idx;
            miss_tag_reg   <= req_tag;
            wr_reg         <= mem_write;
            victim_reg     <= victim_sel;
          end
        end
        WB: begin
          if (pmem_resp) begin
            dirty_reg[idx_reg][victim_reg] <= 1'b0;
            wb_count_reg <= sat_inc(wb_count_reg);
          end
        end
        FILL: begin
          if (pmem_resp) begin
            tag_arr[idx_reg][victim_reg]   <= miss_tag_reg;
            valid_reg[idx_reg][victim_reg] <= 1'b1;
            dirty_reg[idx_reg][victim_reg] <= 1'b0;
          end
        end
        RESP: begin
          if (wr_reg) dirty_reg[idx_reg][victim_reg] <= 1'b1;
          plru_reg[idx_reg] <= plru_touch(plru_reg[idx_reg], victim_reg);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
  assign wb_count   = wb_count_reg;

endmodule

// File: tb/tb_l2cache_ctrl_nway.sv
// Randomized bench for l2cache_ctrl_nway against a set/way/tree model of the cache.
`timescale 1ns/1ps
module tb_l2cache_ctrl_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] pmem_addr;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [1:0]  data_way;
  logic        data_load, data_write, busy;
  logic [31:0] hit_count, miss_count, wb_count;

  l2cache_ctrl_nway dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .data_way(data_way), .data_load(data_load), .data_write(data_write), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference model: 16 sets x 4 ways, PLRU tree as 3 direction bits per set.
  bit          m_valid [16][4];
  bit          m_dirty [16][4];
  logic [22:0] m_tag   [16][4];
  bit          m_tree  [16][3];
  int          exp_hit, exp_miss, exp_wb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = '0;
      end
      for (int n = 0; n < 3; n++) m_tree[s][n] = 0;
    end
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
  endtask

  // Walk the way range by halving; each node records which half was used last.
  task automatic model_touch(input int s, input int w);
    int lo, hi, node, mid;
    lo = 0; hi = 4; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w >= mid) begin m_tree[s][node] = 1; lo = mid; node = 2 * node + 2; end
      else          begin m_tree[s][node] = 0; hi = mid; node = 2 * node + 1; end
    end
  endtask

  function automatic int model_victim(input int s);
    int lo, hi, node, mid;
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    lo = 0; hi = 4; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_tree[s][node]) begin hi = mid; node = 2 * node + 1; end
      else                 begin lo = mid; node = 2 * node + 2; end
    end
    return lo;
  endfunction

  task automatic chk_counters(input string ctx);
    chk({ctx, "_hits"}, hit_count, exp_hit);
    chk({ctx, "_misses"}, miss_count, exp_miss);
    chk({ctx, "_wbs"}, wb_count, exp_wb);
    chk({ctx, "_busy"}, busy, 0);
  endtask

  // Called at posedge+1; returns at posedge+2 with the request released.
  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input int dly, input bit drop);
    int s, hw, v;
    bit vd;
    logic [22:0] t;
    s = int'(addr[8:5]);
    t = addr[31:9];
    hw = -1;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    n_txn++;
    mem_addr = addr; mem_read = rd; mem_write = wr;
    #1;
    if (hw >= 0) begin
      $display("txn %0d addr=%h rd=%0d wr=%0d hit way=%0d", n_txn, addr, rd, wr, hw);
      chk("hit_resp", mem_resp, 1);
      chk("hit_way", data_way, hw);
      chk("hit_dwrite", data_write, wr);
      chk("hit_pmem", {pmem_read, pmem_write}, 0);
      exp_hit++;
      if (wr) m_dirty[s][hw] = 1;
      model_touch(s, hw);
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
    end else begin
      v  = model_victim(s);
      vd = m_valid[s][v] && m_dirty[s][v];
      $display("txn %0d addr=%h rd=%0d wr=%0d miss victim=%0d wb=%0d drop=%0d",
               n_txn, addr, rd, wr, v, vd, drop);
      chk("miss_resp", mem_resp, 0);
      @(posedge clk); #1;
      if (drop) begin mem_read = 0; mem_write = 0; end
      #1;
      if (vd) begin
        chk("wb_write", pmem_write, 1);
        chk("wb_read", pmem_read, 0);
        chk("wb_addr", pmem_addr, {m_tag[s][v], addr[8:5], 5'b0});
        chk("wb_way", data_way, v);
        repeat (dly) @(posedge clk);
        #1;
        chk("wb_hold", pmem_write, 1);
        pmem_resp = 1;
        @(posedge clk); #1;
        pmem_resp = 0;
        #1;
      end
      chk("fill_read", pmem_read, 1);
      chk("fill_write", pmem_write, 0);
      chk("fill_addr", pmem_addr, {addr[31:5], 5'b0});
      chk("fill_way", data_way, v);
      chk("fill_load_early", data_load, 0);
      repeat (dly) @(posedge clk);
      #1;
      pmem_resp = 1;
      #1;
      chk("fill_load", data_load, 1);
      @(posedge clk); #1;
      pmem_resp = 0;
      #1;
      chk("resp_pulse", mem_resp, 1);
      chk("resp_way", data_way, v);
      chk("resp_dwrite", data_write, wr);
      chk("resp_load", data_load, 0);
      exp_miss++;
      if (vd) exp_wb++;
      m_valid[s][v] = 1;
      m_dirty[s][v] = wr;
      m_tag[s][v]   = t;
      model_touch(s, v);
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
    end
    #1;
    chk_counters("post");
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  initial begin
    int kind, gap;
    logic [31:0] a;
    rst = 1; mem_addr = '0; mem_read = 0; mem_write = 0; pmem_resp = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_strobes", {mem_resp, pmem_read, pmem_write, data_load, data_write}, 0);
    chk("rst_way", data_way, 0);
    chk("rst_paddr", pmem_addr, 0);
    chk_counters("rst");

    // Cold miss then hit.
    access(32'h0000_0100, 1, 0, 2, 0);
    access(32'h0000_0100, 1, 0, 0, 0);

    // PLRU replacement in set 0.
    foreach (a[i]) ;
    access(32'h000, 1, 0, 1, 0);
    access(32'h200, 1, 0, 0, 0);
    access(32'h400, 1, 0, 3, 0);
    access(32'h600, 1, 0, 0, 0);
    access(32'h000, 1, 0, 0, 0);
    access(32'h400, 1, 0, 0, 0);
    access(32'h800, 1, 0, 1, 0);
    access(32'h200, 1, 0, 1, 0);

    // Dirty writeback of way 0.
    do_reset();
    access(32'h000, 0, 1, 1, 0);
    access(32'h200, 1, 0, 0, 0);
    access(32'h400, 1, 0, 0, 0);
    access(32'h600, 1, 0, 0, 0);
    access(32'h800, 1, 0, 2, 0);
    chk("plan_wb_count", wb_count, 1);
    chk("plan_miss_count", miss_count, 5);

    // Write hit, then evict that dirty line.
    access(32'h040, 1, 0, 0, 0);
    access(32'h044, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) access(32'h040 + 32'(k) * 32'h200, 1, 0, 1, 0);

    // Reset during FILL.
    do_reset();
    mem_addr = 32'h0000_0a60; mem_read = 1;
    @(posedge clk); #2;
    chk("midfill_read", pmem_read, 1);
    rst = 1; mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("midfill_after_read", pmem_read, 0);
    chk("midfill_after_write", pmem_write, 0);
    model_clear();
    chk_counters("midfill");
    access(32'h0000_0a60, 1, 0, 1, 0);

    // Idle cycles with stray pmem_resp, then dual request on a hit.
    for (int k = 0; k < 10; k++) begin
      pmem_resp = (k % 3 == 0);
      @(posedge clk); #1;
      pmem_resp = 0;
      #1;
      chk("idle_pmem", {pmem_read, pmem_write, mem_resp}, 0);
    end
    chk_counters("idle");
    access(32'h0000_0a60, 1, 1, 0, 0);

    // Randomized traffic over a few sets and tags.
    for (int k = 0; k < 300; k++) begin
      a = {23'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      kind = $urandom_range(1, 3);
      access(a, kind[0], kind[1], $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        pmem_resp = $urandom_range(0, 1);
        @(posedge clk); #1;
        pmem_resp = 0;
      end
      #1;
      if (gap > 0) chk("gap_idle", {busy, pmem_read, pmem_write}, 0);
    end
    chk_counters("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2cache_ctrl_nway.md
Name: l2cache_ctrl_nway

Overview:
Parametrised N-way set-associative write-back L2 cache controller, successor to the fixed direct-mapped L2 control FSM. Holds the tag/valid/dirty/tree-PLRU metadata internally and drives the external line data array through way-select and load strobes. Sits between the L1 arbiter (mem_* side) and physical memory (pmem_* side). Adds miss/hit/writeback performance counters.

Parameters:
WAYS, 4, associativity; power of 2, range 2..8
SETS, 16, number of sets; power of 2; IDX_W = log2(SETS)
ADDR_W, 32, byte address width
OFFSET_W, 5, line offset bits (32-byte line); TAG_W = ADDR_W - IDX_W - OFFSET_W
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset
mem_addr  in  ADDR_W  request byte address; held stable until mem_resp
mem_read  in  1  read request; held until mem_resp
mem_write  in  1  write request; held until mem_resp
mem_resp  out  1  one-cycle completion pulse
pmem_addr  out  ADDR_W  line-aligned physical address (offset bits 0)
pmem_read  out  1  line fill request; held until pmem_resp
pmem_write  out  1  line writeback request; held until pmem_resp
pmem_resp  in  1  physical memory completion pulse
data_way  out  log2(WAYS)  way selected in data array
data_load  out  1  write pmem line into data_way
data_write  out  1  merge L1 write data into data_way
busy  out  1  state != IDLE
hit_count  out  CNT_W  lookups that hit
miss_count  out  CNT_W  lookups that missed
wb_count  out  CNT_W  dirty writebacks completed

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Clears all valid, dirty and PLRU bits and all counters; state = IDLE. All outputs are combinational from state and inputs. In IDLE with no request, all strobes are 0, data_way = 0 and pmem_addr = 0.
- Address split: tag = addr[ADDR_W-1 : IDX_W+OFFSET_W]; idx = addr[IDX_W+OFFSET_W-1 : OFFSET_W].
- mem_read and mem_write asserted together: treated as a write.
- States: IDLE, WB, FILL, RESP.
- IDLE, request present, hit (valid && tag match in exactly one way):
  - mem_resp=1 in the same cycle; data_way = hit way.
  - data_write=1 if write, and that way's dirty bit is set.
  - PLRU updated; hit_count++.
  - Remain in IDLE.
- IDLE, request present, miss:
  - miss_count++.
  - Victim = lowest-index invalid way, else the PLRU victim. The victim is latched.
  - Next state is WB if the victim is valid && dirty, else FILL.
- WB: pmem_write=1; pmem_addr = {victim tag, idx, 0}; data_way = victim. On pmem_resp: wb_count++, clear the victim's dirty bit, go to FILL.
- FILL: pmem_read=1; pmem_addr = {req tag, idx, 0}; data_way = victim. On pmem_resp: data_load=1; write tag, set valid, clear dirty; go to RESP.
- RESP:
  - mem_resp=1; data_way = victim.
  - If write: data_write=1 and dirty set.
  - PLRU updated; no counter change; go to IDLE.
- Miss latency: clean = 1 + fill cycles + 1; dirty adds the writeback cycles.
- Tree PLRU:
  - WAYS-1 bits per set, heap-ordered, root at node 0.
  - On access, each node on the path is set to the direction taken (0 = left/lower ways, 1 = right).
  - Victim walk follows the opposite of each node bit.
- Counters saturate at all-ones; no wrap.
- Request dropped mid-miss: protocol violation; the controller still completes WB/FILL and the RESP pulse.
- rst mid-operation (WB/FILL): next cycle state = IDLE and pmem_read/pmem_write = 0. The outstanding pmem transaction is abandoned and all metadata is invalidated.
- pmem_resp outside WB/FILL: ignored.

Test Plan:
(WAYS=4, SETS=16, OFFSET_W=5, ADDR_W=32.)
1. Cold read miss then hit.
   - After reset, read 0x0000_0100 -> miss_count=1; FILL with pmem_addr=0x100, data_way=0.
   - After pmem_resp: data_load, then RESP mem_resp.
   - Repeat read -> mem_resp same cycle, hit_count=1, pmem idle.
2. PLRU replacement.
   - Read 0x000, 0x200, 0x400, 0x600 (set 0, fill ways 0-3), then hit 0x000 and 0x400.
   - Read 0x800 -> victim way 1; pmem_read only, no pmem_write.
   - Subsequent read of 0x200 misses.
3. Dirty writeback.
   - Write 0x000 (miss, way 0 dirty); read 0x200, 0x400, 0x600.
   - Read 0x800 -> WB with pmem_write, pmem_addr=0x000, data_way=0; then FILL with pmem_addr=0x800.
   - wb_count=1, miss_count=5.
4. Write hit.
   - Read 0x040 (fills set 2), then write 0x040 -> same-cycle mem_resp with data_write=1.
   - Evicting that line later produces a writeback.
5. Reset mid-FILL.
   - Pulse rst while pmem_read=1 -> next cycle pmem_read=0, busy=0, all counters 0.
   - Re-read of the same address misses.
6. Idle and dual request.
   - No request for 10 cycles -> no counter or pmem activity.
   - mem_read=mem_write=1 on a hit -> data_write=1 (handled as write).
